// File: rtl/ahb_error_slave.sv
// AHB-Lite default slave: every accepted transfer gets a two-cycle ERROR response, optionally delayed by wait states.
// Optional error log (ERR_CLR/ERR_ADDR/ERR_WRITE/ERR_COUNT) is built when AHB_ERROR_SLAVE_ERRLOG_EN is defined.
module ahb_error_slave #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
  ,
  input  logic              ERR_CLR,
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic              ERR_WRITE,
  output logic [CNT_W-1:0]  ERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;

  // Only IDLE and ERR2 drive HREADYOUT high, so only they can take a new address phase.
  assign accept = HSEL && HREADY && HTRANS[1] &&
                  ((state_q == S_IDLE) || (state_q == S_ERR2));

  assign HRDATA = '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ERR1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ERR1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ERR1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Outputs are flopped from the next state so they match the state register exactly.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      HREADYOUT <= (state_d == S_IDLE) || (state_d == S_ERR2);
      HRESP     <= (state_d == S_ERR1) || (state_d == S_ERR2);
    end
  end

`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
  // Capture beats clear for address/direction; clear beats capture for the count.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      ERR_ADDR  <= '0;
      ERR_WRITE <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      if (accept) begin
        ERR_ADDR  <= HADDR;
        ERR_WRITE <= HWRITE;
      end else if (ERR_CLR) begin
        ERR_ADDR  <= '0;
        ERR_WRITE <= 1'b0;
      end
      if (ERR_CLR) begin
        ERR_COUNT <= '0;
      end else if (accept && (ERR_COUNT != {CNT_W{1'b1}})) begin
        ERR_COUNT <= ERR_COUNT + CNT_W'(1);
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HTRANS[0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HTRANS[0], HADDR, HWRITE};
`endif

endmodule

// File: tb/tb_ahb_error_slave.sv
// Bench for ahb_error_slave: two instances (0 and 3 wait states) driven by shared directed and random stimulus,
// checked against a response-schedule model; error log checks are active when AHB_ERROR_SLAVE_ERRLOG_EN is defined.
module tb_ahb_error_slave;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int WS0    = 0;
  localparam int WS1    = 3;
  localparam int CW0    = 2;
  localparam int CW1    = 16;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic              hsel = 1'b0;
  logic [ADDR_W-1:0] haddr = '0;
  logic [1:0]        htrans = 2'b00;
  logic              hwrite = 1'b0;
  logic [2:0]        hsize = 3'd3;
  logic [2:0]        hburst = 3'd0;
  logic [3:0]        hprot = 4'd3;
  logic              hmastlock = 1'b0;
  logic [DATA_W-1:0] hwdata = '0;
  logic              err_clr = 1'b0;
  logic              hready0 = 1'b1;
  logic              hready1 = 1'b1;

  logic [DATA_W-1:0] hrdata0, hrdata1;
  logic              hreadyout0, hreadyout1, hresp0, hresp1;
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
  logic [ADDR_W-1:0] err_addr0, err_addr1;
  logic              err_write0, err_write1;
  logic [CW0-1:0]    err_count0;
  logic [CW1-1:0]    err_count1;
`endif

  ahb_error_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_STATES(WS0), .CNT_W(CW0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HREADY(hready0),
    .HWDATA(hwdata), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_ADDR(err_addr0), .ERR_WRITE(err_write0), .ERR_COUNT(err_count0)
`endif
  );

  ahb_error_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_STATES(WS1), .CNT_W(CW1)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HREADY(hready1),
    .HWDATA(hwdata), .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_ADDR(err_addr1), .ERR_WRITE(err_write1), .ERR_COUNT(err_count1)
`endif
  );

  // ---------------- scoreboard / model ----------------
  // Each queue entry is the {HREADYOUT,HRESP} pair expected for one future cycle; empty means idle OKAY.
  logic [1:0]        exp_q0[$];
  logic [1:0]        exp_q1[$];
  logic [ADDR_W-1:0] m_addr[2];
  logic              m_write[2];
  int                m_cnt[2];
  int                checks = 0;
  int                failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] front(int k);
    if (k == 0) return (exp_q0.size() > 0) ? exp_q0[0] : 2'b10;
    return (exp_q1.size() > 0) ? exp_q1[0] : 2'b10;
  endfunction

  task automatic model_update(int k, logic acc, logic [ADDR_W-1:0] addr, logic wr, logic clr);
    int ws;
    int cmax;
    ws   = (k == 0) ? WS0 : WS1;
    cmax = (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
    if (k == 0) begin
      if (exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (acc) begin
        repeat (ws) exp_q0.push_back(2'b00);
        exp_q0.push_back(2'b01);
        exp_q0.push_back(2'b11);
      end
    end else begin
      if (exp_q1.size() > 0) void'(exp_q1.pop_front());
      if (acc) begin
        repeat (ws) exp_q1.push_back(2'b00);
        exp_q1.push_back(2'b01);
        exp_q1.push_back(2'b11);
      end
    end
    if (clr) m_cnt[k] = 0;
    else if (acc && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
    if (acc) begin
      m_addr[k]  = addr;
      m_write[k] = wr;
    end else if (clr) begin
      m_addr[k]  = '0;
      m_write[k] = 1'b0;
    end
  endtask

  task automatic check_logs(string tag);
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    chk({tag, "_addr0"}, 64'(err_addr0), 64'(m_addr[0]));
    chk({tag, "_wr0"}, 64'(err_write0), 64'(m_write[0]));
    chk({tag, "_cnt0"}, 64'(err_count0), 64'(m_cnt[0]));
    chk({tag, "_addr1"}, 64'(err_addr1), 64'(m_addr[1]));
    chk({tag, "_wr1"}, 64'(err_write1), 64'(m_write[1]));
    chk({tag, "_cnt1"}, 64'(err_count1), 64'(m_cnt[1]));
`else
    chk({tag, "_nolog"}, 64'(hrdata0 | hrdata1), 64'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle: check the outputs of the current cycle, drive inputs, advance the model at the edge.
  task automatic step(logic sel, logic [1:0] tr, logic [ADDR_W-1:0] addr, logic wr, logic clr, logic hd);
    logic [1:0] e0, e1;
    logic a0, a1;
    @(negedge HCLK);
    e0 = front(0);
    e1 = front(1);
    chk("bus0", 64'({hreadyout0, hresp0}), 64'(e0));
    chk("bus1", 64'({hreadyout1, hresp1}), 64'(e1));
    chk("rdata0", 64'(hrdata0), 64'd0);
    chk("rdata1", 64'(hrdata1), 64'd0);
    check_logs("log");
    hsel    = sel;
    htrans  = tr;
    haddr   = addr;
    hwrite  = wr;
    hwdata  = {$urandom(), $urandom()};
    err_clr = clr;
    hready0 = e0[1] & ~hd;
    hready1 = e1[1] & ~hd;
    @(posedge HCLK);
    a0 = sel & hready0 & tr[1];
    a1 = sel & hready1 & tr[1];
    model_update(0, a0, addr, wr, clr);
    model_update(1, a1, addr, wr, clr);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(string tag);
    #2 HRESET = 1'b0;
    #1;
    chk({tag, "_rdy0"}, 64'(hreadyout0), 64'd1);
    chk({tag, "_resp0"}, 64'(hresp0), 64'd0);
    chk({tag, "_rdy1"}, 64'(hreadyout1), 64'd1);
    chk({tag, "_resp1"}, 64'(hresp1), 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_addr[k]  = '0;
      m_write[k] = 1'b0;
      m_cnt[k]   = 0;
    end
    check_logs(tag);
    hsel    = 1'b0;
    htrans  = 2'b00;
    err_clr = 1'b0;
    hready0 = 1'b1;
    hready1 = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [1:0]        exp_seq0[6];
  logic [1:0]        exp_seq1[6];
  logic [1:0]        pair_seq[5];
  logic [ADDR_W-1:0] addr_b;
  int                cnt_before;

  initial begin
    do_reset("reset");

    // Single read then single write: 0 and 3 wait-state response shapes.
    exp_seq0 = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    exp_seq1 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < 6; c++) begin
        if (c == 0) step(1'b1, 2'b10, 32'h0000_1400, t[0], 1'b0, 1'b0);
        else idle_step();
        chk($sformatf("single%0d_c%0d_i0", t, c), 64'({hreadyout0, hresp0}), 64'(exp_seq0[c]));
        chk($sformatf("single%0d_c%0d_i1", t, c), 64'({hreadyout1, hresp1}), 64'(exp_seq1[c]));
      end
    end

    // IDLE and BUSY with HSEL=1 are never accepted.
    cnt_before = m_cnt[0];
    for (int c = 0; c < 5; c++) begin
      step(1'b1, c[0] ? 2'b01 : 2'b00, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
      chk($sformatf("idlebusy_c%0d", c), 64'({hreadyout0, hresp0, hreadyout1, hresp1}), 64'b1010);
    end
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    chk("idlebusy_cnt", 64'(err_count0), 64'(cnt_before));
`endif

    // Back-to-back: second transfer presented in the ERR2 cycle.
    do_reset("b2b_rst");
    addr_b   = 32'h0000_3004;
    pair_seq = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) step(1'b1, 2'b10, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
      else if (c == 2) step(1'b1, 2'b10, addr_b, 1'b1, 1'b0, 1'b0);
      else idle_step();
      chk($sformatf("b2b_c%0d", c), 64'({hreadyout0, hresp0}), 64'(pair_seq[c]));
    end
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    chk("b2b_cnt", 64'(err_count0), 64'd2);
    chk("b2b_addr", 64'(err_addr0), 64'(addr_b));
    chk("b2b_wr", 64'(err_write0), 64'd1);
`endif
    repeat (6) idle_step();

    // Reset pulsed during ERR1 aborts the response.
    step(1'b1, 2'b10, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
    chk("abort_err1", 64'({hreadyout0, hresp0}), 64'b01);
    do_reset("abort");
    idle_step();
    chk("abort_after", 64'({hreadyout0, hresp0, hreadyout1, hresp1}), 64'b1010);

    // Five errored transfers saturate the 2-bit counter, then clear.
    do_reset("sat_rst");
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 2'b11, $urandom(), 1'(n), 1'b0, 1'b0);
      idle_step();
      idle_step();
    end
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    chk("sat_cnt", 64'(err_count0), 64'd3);
`endif
    repeat (4) idle_step();
    step(1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0);
`ifdef AHB_ERROR_SLAVE_ERRLOG_EN
    chk("clr_cnt", 64'(err_count0), 64'd0);
    chk("clr_addr", 64'(err_addr0), 64'd0);
`endif

    // Randomized traffic, including foreign wait states and clear/capture collisions.
    do_reset("rand_rst");
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
    end
    repeat (8) idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
